decode_stage: RTL and testbench

Registered, parametrised instruction decode stage for TinyCPU. It accepts raw instruction words over a valid/ready handshake and translates per-type field slices into one semantic bundle: sources, destination, enables, ALU op and extended immediate. A two-entry skid buffer sits between fetch and the register-read/execute stage. The stage also flags illegal instruction types, supports a synchronous flush, and keeps a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 30 +++
 rtl/decode_skid.sv | 76 +++++++
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared type codes and field helpers for the TinyCPU decode stage.
package decode_pkg;

    localparam int TYPE_NOP      = 0;
    localparam int TYPE_LOAD_IMM = 1;
    localparam int TYPE_LOAD_MEM = 2;
    localparam int TYPE_STORE    = 3;
    localparam int TYPE_ALU      = 4;
    localparam int TYPE_JUMP     = 5;

    localparam int NUM_TYPES_DEFAULT = 6;

    // Widest instruction word the slice helper can handle.
    localparam int FIELD_MAX_W = 64;

    function automatic logic [FIELD_MAX_W-1:0] field_at(
        input logic [FIELD_MAX_W-1:0] word,
        input int unsigned            lsb,
        input int unsigned            width
    );
        logic [FIELD_MAX_W-1:0] mask;
        if (width >= FIELD_MAX_W) begin
            mask = '1;
        end else begin
            mask = (FIELD_MAX_W'(1) << width) - FIELD_MAX_W'(1);
        end
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry valid/ready skid buffer: main register drives the output,
// skid register absorbs one accept while the consumer stalls.
module decode_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q;
    logic             accept;
    logic             deliver;

    assign accept  = in_valid & in_ready_q;
    assign deliver = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_d     = '0;
            skid_d     = '0;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || deliver) begin
            // in_ready is low whenever skid is full, so accept cannot collide with the skid drain
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_data;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= ~skid_vld_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/decode_stage.sv
// TinyCPU decode stage: combinational field decode into a semantic bundle,
// buffered by a 2-entry skid, with a saturating illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int TYPE_W     = 5,
    parameter int REG_W      = 5,
    parameter int ALU_OP_W   = 5,
    parameter int IMM_W      = 16,
    parameter int DATA_W     = 32,
    parameter int IMM_SIGNED = 0,
    parameter int NUM_TYPES  = NUM_TYPES_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TYPE_W-1:0]   out_type,
    output logic                out_illegal,
    output logic [REG_W-1:0]    out_rs0,
    output logic [REG_W-1:0]    out_rs1,
    output logic [REG_W-1:0]    out_rd,
    output logic                out_rs0_en,
    output logic                out_rs1_en,
    output logic                out_rd_en,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [DATA_W-1:0]   out_imm,
    output logic [CNT_W-1:0]    illegal_count
);

    localparam int TYPE_LSB = INSTR_W - TYPE_W;
    localparam int A_LSB    = TYPE_LSB - REG_W;
    localparam int B_LSB    = A_LSB - REG_W;
    localparam int C_LSB    = B_LSB - REG_W;
    localparam int OP_LSB   = C_LSB - ALU_OP_W;
    localparam int IMM_LSB  = TYPE_LSB - IMM_W;
    localparam int IR_LSB   = IMM_LSB - REG_W;
    localparam int BUNDLE_W = TYPE_W + 1 + 3 * REG_W + 3 + ALU_OP_W + DATA_W;

    if (OP_LSB < 0 || IR_LSB < 0 || DATA_W < IMM_W || INSTR_W > FIELD_MAX_W) begin : g_bad_cfg
        $error("decode_stage: field layout does not fit the instruction word");
    end

    logic [TYPE_W-1:0]   f_type;
    logic [REG_W-1:0]    f_a, f_b, f_c, f_ir;
    logic [ALU_OP_W-1:0] f_op;
    logic [IMM_W-1:0]    f_imm;
    logic [DATA_W-1:0]   f_imm_ext;

    assign f_type = TYPE_W'(field_at(FIELD_MAX_W'(in_instr), TYPE_LSB, TYPE_W));
    assign f_a    = REG_W'(field_at(FIELD_MAX_W'(in_instr), A_LSB, REG_W));
    assign f_b    = REG_W'(field_at(FIELD_MAX_W'(in_instr), B_LSB, REG_W));
    assign f_c    = REG_W'(field_at(FIELD_MAX_W'(in_instr), C_LSB, REG_W));
    assign f_op   = ALU_OP_W'(field_at(FIELD_MAX_W'(in_instr), OP_LSB, ALU_OP_W));
    assign f_imm  = IMM_W'(field_at(FIELD_MAX_W'(in_instr), IMM_LSB, IMM_W));
    assign f_ir   = REG_W'(field_at(FIELD_MAX_W'(in_instr), IR_LSB, REG_W));

    assign f_imm_ext = (IMM_SIGNED != 0) ? DATA_W'($signed(f_imm)) : DATA_W'(f_imm);

    logic                dec_illegal;
    logic [REG_W-1:0]    dec_rs0, dec_rs1, dec_rd;
    logic                dec_rs0_en, dec_rs1_en, dec_rd_en;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic [DATA_W-1:0]   dec_imm;

    always_comb begin
        dec_illegal = (32'(f_type) >= 32'(NUM_TYPES));
        dec_rs0     = '0;
        dec_rs1     = '0;
        dec_rd      = '0;
        dec_rs0_en  = 1'b0;
        dec_rs1_en  = 1'b0;
        dec_rd_en   = 1'b0;
        dec_alu_op  = '0;
        dec_imm     = '0;
        if (!dec_illegal) begin
            case (32'(f_type))
                TYPE_LOAD_IMM: begin
                    dec_rd    = f_ir;
                    dec_rd_en = 1'b1;
                    dec_imm   = f_imm_ext;
                end
                TYPE_LOAD_MEM: begin
                    dec_rs0    = f_a;
                    dec_rd     = f_b;
                    dec_rs0_en = 1'b1;
                    dec_rd_en  = 1'b1;
                end
                TYPE_STORE, TYPE_JUMP: begin
                    dec_rs0    = f_a;
                    dec_rs1    = f_b;
                    dec_rs0_en = 1'b1;
                    dec_rs1_en = 1'b1;
                end
                TYPE_ALU: begin
                    dec_rs0    = f_a;
                    dec_rs1    = f_b;
                    dec_rd     = f_c;
                    dec_alu_op = f_op;
                    dec_rs0_en = 1'b1;
                    dec_rs1_en = 1'b1;
                    dec_rd_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [BUNDLE_W-1:0] dec_bundle;
    logic [BUNDLE_W-1:0] out_bundle;

    assign dec_bundle = {f_type, dec_illegal, dec_rs0, dec_rs1, dec_rd,
                         dec_rs0_en, dec_rs1_en, dec_rd_en, dec_alu_op, dec_imm};

    decode_skid #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle)
    );

    assign {out_type, out_illegal, out_rs0, out_rs1, out_rd,
            out_rs0_en, out_rs1_en, out_rd_en, out_alu_op, out_imm} = out_bundle;

    // Counted on delivery, so a handshake coinciding with flush still counts.
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    always_comb begin
        illegal_count_d = illegal_count_q;
        if (out_valid && out_ready && out_illegal && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_count_q <= '0;
        end else begin
            illegal_count_q <= illegal_count_d;
        end
    end

    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus a sign-extending,
// 2-bit-counter instance fed the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [4:0]  out_type, out_rs0, out_rs1, out_rd, out_alu_op;
    logic        out_rs0_en, out_rs1_en, out_rd_en;
    logic [31:0] out_imm;
    logic [15:0] illegal_count;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [4:0]  out_type_b, out_rs0_b, out_rs1_b, out_rd_b, out_alu_op_b;
    logic        out_rs0_en_b, out_rs1_en_b, out_rd_en_b;
    logic [31:0] out_imm_b;
    logic [1:0]  illegal_count_b;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_ALU   = 32'h20CA7100;
    localparam logic [31:0] I_LIMM  = 32'h0C000A40;
    localparam logic [31:0] I_ILL   = 32'hF8000000;
    localparam logic [31:0] I_STORE = 32'h18440000;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_illegal(out_illegal),
        .out_rs0(out_rs0), .out_rs1(out_rs1), .out_rd(out_rd),
        .out_rs0_en(out_rs0_en), .out_rs1_en(out_rs1_en), .out_rd_en(out_rd_en),
        .out_alu_op(out_alu_op), .out_imm(out_imm), .illegal_count(illegal_count)
    );

    decode_stage #(.IMM_SIGNED(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_type(out_type_b), .out_illegal(out_illegal_b),
        .out_rs0(out_rs0_b), .out_rs1(out_rs1_b), .out_rd(out_rd_b),
        .out_rs0_en(out_rs0_en_b), .out_rs1_en(out_rs1_en_b), .out_rd_en(out_rd_en_b),
        .out_alu_op(out_alu_op_b), .out_imm(out_imm_b), .illegal_count(illegal_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ens();
        return {29'd0, out_rs0_en, out_rs1_en, out_rd_en};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(illegal_count), 32'd0);
        chk("rst_data", {out_rs0, out_rs1, out_rd, out_alu_op, 12'd0}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);

        rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ALU then LOAD_IMM back to back with out_ready high
        in_valid = 1'b1; in_instr = I_ALU; out_ready = 1'b1;
        tick();
        in_instr = I_LIMM;
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_type", 32'(out_type), 32'd4);
        chk("alu_rs0", 32'(out_rs0), 32'd3);
        chk("alu_rs1", 32'(out_rs1), 32'd5);
        chk("alu_rd", 32'(out_rd), 32'd7);
        chk("alu_op", 32'(out_alu_op), 32'd2);
        chk("alu_en", ens(), 32'd7);
        chk("alu_illegal", 32'(out_illegal), 32'd0);
        tick();
        in_instr = I_ILL;
        chk("limm_valid", 32'(out_valid), 32'd1);
        chk("limm_rd", 32'(out_rd), 32'd9);
        chk("limm_en", ens(), 32'd1);
        chk("limm_imm_zext", out_imm, 32'h00008001);
        chk("limm_imm_sext", out_imm_b, 32'hFFFF8001);
        chk("limm_rs0", 32'(out_rs0), 32'd0);

        tick();
        in_valid = 1'b0;
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_type", 32'(out_type), 32'd31);
        chk("ill_en", ens(), 32'd0);
        chk("ill_fields", {out_rs0, out_rs1, out_rd, out_alu_op, 12'd0}, 32'd0);
        chk("ill_count_pre", 32'(illegal_count), 32'd0);
        tick();
        chk("ill_count_1", 32'(illegal_count), 32'd1);
        chk("ill_drained", 32'(out_valid), 32'd0);

        // three more illegals: 16-bit count reaches 4, 2-bit count saturates at 3
        in_valid = 1'b1; in_instr = I_ILL;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("count_4", 32'(illegal_count), 32'd4);
        chk("count_sat", 32'(illegal_count_b), 32'd3);

        // stall with three back-to-back valids
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ALU;
        tick();
        in_instr = I_LIMM;
        chk("stall1_in_ready", 32'(in_ready), 32'd1);
        chk("stall1_type", 32'(out_type), 32'd4);
        tick();
        in_instr = I_STORE;
        chk("stall2_in_ready", 32'(in_ready), 32'd0);
        chk("stall2_type", 32'(out_type), 32'd4);
        tick();
        chk("stall3_in_ready", 32'(in_ready), 32'd0);
        chk("stall3_rs0", 32'(out_rs0), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("rel1_type", 32'(out_type), 32'd1);
        chk("rel1_rd", 32'(out_rd), 32'd9);
        chk("rel1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rel2_type", 32'(out_type), 32'd3);
        chk("rel2_rs", {22'd0, out_rs0, out_rs1}, 32'h22);
        chk("rel2_en", ens(), 32'd6);
        tick();
        chk("rel_drained", 32'(out_valid), 32'd0);

        // flush with both entries full plus an offered instruction
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ALU;
        tick();
        in_instr = I_LIMM;
        tick();
        in_instr = I_STORE; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("flush_nothing_out", 32'(out_valid), 32'd0);

        // flush discards a same-cycle accept
        in_valid = 1'b1; in_instr = I_ALU; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_acc_discard", 32'(out_valid), 32'd0);

        // flush coinciding with an illegal handshake still counts it
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ILL;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        chk("flush_hs_pre", 32'(illegal_count), 32'd4);
        tick();
        flush = 1'b0;
        chk("flush_hs_count", 32'(illegal_count), 32'd5);
        chk("flush_hs_valid", 32'(out_valid), 32'd0);

        // reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ALU;
        tick();
        chk("mid_valid_pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(illegal_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_type", 32'(out_type), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
